// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : otter_cu_fsm
// Purpose  : Multicycle control-unit state machine for the OTTER RV32I core.
//            Steps each instruction through fetch, execute and optional
//            writeback / interrupt-entry cycles, and drives every
//            state-dependent strobe (PC, register file, memories, CSR,
//            interrupt). Datapath mux selects come from the decoder.
// Ports    : CLK, RST (async, active-high)
//            INTR          - interrupt request, already CSR-gated
//            opcode, func3 - ir[6:0], ir[14:12]
//            PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
//            csr_WE, int_taken, mret_exec - strobes (all default 0)
//            dbg_state     - current state code
// Revision : 1.0 - initial release
// ============================================================================
module otter_cu_fsm #(
  parameter int SYNC_INTR = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output logic       PCWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_INTR  = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RG3    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       intr_eff;

  // Effective interrupt: either a 2-flop synchronised copy or the raw input.
  generate
    if (SYNC_INTR != 0) begin : g_sync
      logic sync1_q;
      logic sync2_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= INTR;
          sync2_q <= sync1_q;
        end
      end
      assign intr_eff = sync2_q;
    end else begin : g_nosync
      assign intr_eff = INTR;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next state. The interrupt is only looked at on the last cycle of an
  // instruction (EXEC of a non-load, or WB); ST_INTR never re-checks it.
  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_LOAD) state_d = ST_WB;
        else if (intr_eff)     state_d = ST_INTR;
        else                   state_d = ST_FETCH;
      end
      ST_WB:    state_d = intr_eff ? ST_INTR : ST_FETCH;
      ST_INTR:  state_d = ST_FETCH;
      default:  state_d = ST_INIT;
    endcase
  end

  // Strobes. While RST is high the state is already ST_INIT, so the INIT
  // decode gives the required reset-time outputs with no extra gating.
  always_comb begin
    PCWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    reset     = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (state_q)
      ST_INIT:  reset    = 1'b1;
      ST_FETCH: memRDEN1 = 1'b1;
      ST_EXEC: begin
        case (opcode)
          OP_LOAD: memRDEN2 = 1'b1;  // PC advances in WB instead
          OP_STORE: begin
            memWE2  = 1'b1;
            PCWrite = 1'b1;
          end
          OP_IMM, OP_RG3, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            PCWrite  = 1'b1;
            regWrite = 1'b1;
          end
          OP_SYSTEM: begin
            PCWrite = 1'b1;
            case (func3)
              3'b000: mret_exec = 1'b1;
              3'b001, 3'b010, 3'b011: begin
                csr_WE   = 1'b1;
                regWrite = 1'b1;
              end
              default: ;
            endcase
          end
          // BRANCH and unknown opcodes only advance the PC
          OP_BRANCH: PCWrite = 1'b1;
          default:   PCWrite = 1'b1;
        endcase
      end
      ST_WB: begin
        regWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      ST_INTR: begin
        int_taken = 1'b1;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_cu_fsm
// Purpose  : Self-checking bench for otter_cu_fsm. Two instances (synchronised
//            and raw interrupt) share the stimulus; each is compared every
//            cycle against a behavioural model, plus a decode table and
//            hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       INTR = 1'b0;
  logic [6:0] opcode = 7'b0010011;
  logic [2:0] func3 = 3'b000;

  // Packed outputs: {PCWrite,regWrite,memWE2,memRDEN1,memRDEN2,reset,
  //                  csr_WE,int_taken,mret_exec,dbg_state[2:0]}
  logic [11:0] out_s, out_a;
  logic s_pcw, s_rw, s_we, s_rd1, s_rd2, s_rst, s_csr, s_int, s_mret;
  logic a_pcw, a_rw, a_we, a_rd1, a_rd2, a_rst, a_csr, a_int, a_mret;
  logic [2:0] s_dbg, a_dbg;

  otter_cu_fsm #(.SYNC_INTR(1)) u_s (
    .CLK(CLK), .RST(RST), .INTR(INTR), .opcode(opcode), .func3(func3),
    .PCWrite(s_pcw), .regWrite(s_rw), .memWE2(s_we), .memRDEN1(s_rd1),
    .memRDEN2(s_rd2), .reset(s_rst), .csr_WE(s_csr), .int_taken(s_int),
    .mret_exec(s_mret), .dbg_state(s_dbg)
  );

  otter_cu_fsm #(.SYNC_INTR(0)) u_a (
    .CLK(CLK), .RST(RST), .INTR(INTR), .opcode(opcode), .func3(func3),
    .PCWrite(a_pcw), .regWrite(a_rw), .memWE2(a_we), .memRDEN1(a_rd1),
    .memRDEN2(a_rd2), .reset(a_rst), .csr_WE(a_csr), .int_taken(a_int),
    .mret_exec(a_mret), .dbg_state(a_dbg)
  );

  assign out_s = {s_pcw, s_rw, s_we, s_rd1, s_rd2, s_rst, s_csr, s_int, s_mret, s_dbg};
  assign out_a = {a_pcw, a_rw, a_we, a_rd1, a_rd2, a_rst, a_csr, a_int, a_mret, a_dbg};

  always #5 CLK = ~CLK;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011,
                         OPIMM = 7'b0010011, OPRG = 7'b0110011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                         SYS = 7'b1110011, FENCE = 7'b0001111;

  int tests = 0;
  int fails = 0;

  // Model: phase of the current instruction (0 init,1 fetch,2 exec,3 wb,4 intr)
  int   ms = 0, ma = 0;
  logic h1 = 1'b0, h2 = 1'b0;   // INTR history for the 2-cycle delay
  logic [11:0] last_s, last_a;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected strobes derived directly from what each phase is supposed to do.
  function automatic logic [11:0] exp_out(input int st, input logic [6:0] op,
                                          input logic [2:0] f3);
    logic pcw, rw, we, rd1, rd2, rs, csr, it, mr;
    {pcw, rw, we, rd1, rd2, rs, csr, it, mr} = '0;
    if (st == 0) rs = 1'b1;
    else if (st == 1) rd1 = 1'b1;
    else if (st == 3) begin rw = 1'b1; pcw = 1'b1; end
    else if (st == 4) begin it = 1'b1; pcw = 1'b1; end
    else if (st == 2) begin
      pcw = (op != LOAD);
      rd2 = (op == LOAD);
      we  = (op == STORE);
      rw  = (op inside {OPIMM, OPRG, LUI, AUIPC, JAL, JALR}) ||
            (op == SYS && f3 inside {3'b001, 3'b010, 3'b011});
      csr = (op == SYS && f3 inside {3'b001, 3'b010, 3'b011});
      mr  = (op == SYS && f3 == 3'b000);
    end
    return {pcw, rw, we, rd1, rd2, rs, csr, it, mr, 3'(st)};
  endfunction

  // Instruction ends after exec (non-load) or wb; only then may an interrupt enter.
  function automatic int nxt(input int st, input logic [6:0] op, input logic eff);
    if (st == 0) return 1;
    if (st == 1) return 2;
    if (st == 2 && op == LOAD) return 3;
    if (st == 2 || st == 3) return eff ? 4 : 1;
    return 1;
  endfunction

  // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3,
                     input logic intr, input logic rst);
    logic eff_s;
    @(negedge CLK);
    opcode = op; func3 = f3; INTR = intr; RST = rst;
    if (rst) begin ms = 0; ma = 0; h1 = 1'b0; h2 = 1'b0; end
    #1;
    last_s = out_s;
    last_a = out_a;
    chk("model_sync", out_s, exp_out(ms, op, f3));
    chk("model_raw",  out_a, exp_out(ma, op, f3));
    @(posedge CLK);
    if (!rst) begin
      eff_s = h2;
      ms = nxt(ms, op, eff_s);
      ma = nxt(ma, op, intr);
      h2 = h1;
      h1 = intr;
    end
    #1;
  endtask

  task automatic to_fetch();
    cyc(OPIMM, 3'b000, 1'b0, 1'b1);
    cyc(OPIMM, 3'b000, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [5:0] exp;   // {PCWrite,regWrite,memWE2,memRDEN2,csr_WE,mret_exec}
  } vec_t;

  vec_t tbl[15];
  logic [6:0] ops[11];

  initial begin
    tbl[0]  = '{LOAD,   3'b010, 6'b000100};
    tbl[1]  = '{STORE,  3'b010, 6'b101000};
    tbl[2]  = '{BRANCH, 3'b000, 6'b100000};
    tbl[3]  = '{OPIMM,  3'b000, 6'b110000};
    tbl[4]  = '{OPRG,   3'b000, 6'b110000};
    tbl[5]  = '{LUI,    3'b000, 6'b110000};
    tbl[6]  = '{AUIPC,  3'b000, 6'b110000};
    tbl[7]  = '{JAL,    3'b000, 6'b110000};
    tbl[8]  = '{JALR,   3'b000, 6'b110000};
    tbl[9]  = '{SYS,    3'b000, 6'b100001};
    tbl[10] = '{SYS,    3'b001, 6'b110010};
    tbl[11] = '{SYS,    3'b010, 6'b110010};
    tbl[12] = '{SYS,    3'b011, 6'b110010};
    tbl[13] = '{SYS,    3'b101, 6'b100000};
    tbl[14] = '{FENCE,  3'b000, 6'b100000};
    ops = '{LOAD, STORE, BRANCH, OPIMM, OPRG, LUI, AUIPC, JAL, JALR, SYS, FENCE};

    // Startup: RST for 3 cycles, then INIT, FETCH, EXEC, FETCH
    for (int i = 0; i < 3; i++) begin
      cyc(OPIMM, 3'b000, 1'b0, 1'b1);
      chk("rst_reset_out", {11'd0, last_s[6]}, 12'd1);
    end
    cyc(OPIMM, 3'b000, 1'b0, 1'b0);
    chk("init_reset_after", {11'd0, last_s[6]}, 12'd1);
    chk("seq_fetch", {9'd0, s_dbg}, 12'd1);
    cyc(OPIMM, 3'b000, 1'b0, 1'b0);
    chk("fetch_rden1", {11'd0, last_s[8]}, 12'd1);
    chk("seq_exec", {9'd0, s_dbg}, 12'd2);
    cyc(OPIMM, 3'b000, 1'b0, 1'b0);
    chk("addi_pcw_rw", {10'd0, last_s[11:10]}, 12'd3);
    chk("addi_no_mem", {10'd0, last_s[9], last_s[7]}, 12'd0);
    chk("seq_fetch2", {9'd0, s_dbg}, 12'd1);

    // Exec-cycle decode table
    foreach (tbl[i]) begin
      cyc(tbl[i].op, tbl[i].f3, 1'b0, 1'b0);
      cyc(tbl[i].op, tbl[i].f3, 1'b0, 1'b0);
      chk($sformatf("decode_%0d", i),
          {6'd0, last_s[11:9], last_s[7], last_s[5], last_s[3]}, {6'd0, tbl[i].exp});
      if (tbl[i].op == LOAD) cyc(LOAD, 3'b010, 1'b0, 1'b0);
    end

    // LW then SW
    to_fetch();
    cyc(LOAD, 3'b010, 1'b0, 1'b0);
    cyc(LOAD, 3'b010, 1'b0, 1'b0);
    chk("lw_exec", {9'd0, last_s[11], last_s[10], last_s[7]}, 12'b001);
    chk("lw_to_wb", {9'd0, s_dbg}, 12'd3);
    cyc(LOAD, 3'b010, 1'b0, 1'b0);
    chk("lw_wb", {10'd0, last_s[11:10]}, 12'd3);
    cyc(STORE, 3'b010, 1'b0, 1'b0);
    cyc(STORE, 3'b010, 1'b0, 1'b0);
    chk("sw_exec", {10'd0, last_s[9], last_s[10]}, 12'b10);
    chk("sw_done", {9'd0, s_dbg}, 12'd1);

    // Interrupt: raised during FETCH of an ADDI
    to_fetch();
    cyc(OPIMM, 3'b000, 1'b1, 1'b0);
    cyc(OPIMM, 3'b000, 1'b1, 1'b0);
    chk("sync_no_intr_yet", {9'd0, s_dbg}, 12'd1);
    chk("raw_intr_entry", {9'd0, a_dbg}, 12'd4);
    cyc(OPIMM, 3'b000, 1'b0, 1'b0);
    chk("raw_intr_taken", {11'd0, last_a[4]}, 12'd1);
    chk("raw_back_fetch", {9'd0, a_dbg}, 12'd1);
    cyc(OPIMM, 3'b000, 1'b0, 1'b0);
    chk("sync_intr_entry", {9'd0, s_dbg}, 12'd4);
    cyc(OPIMM, 3'b000, 1'b0, 1'b0);
    chk("sync_intr_taken", {11'd0, last_s[4]}, 12'd1);

    // Interrupt arriving on the final cycle of an mret
    to_fetch();
    cyc(SYS, 3'b000, 1'b0, 1'b0);
    cyc(SYS, 3'b000, 1'b1, 1'b0);
    chk("mret_then_intr", {9'd0, a_dbg}, 12'd4);

    // Async reset during WB of a load
    to_fetch();
    cyc(LOAD, 3'b010, 1'b0, 1'b0);
    cyc(LOAD, 3'b010, 1'b0, 1'b0);
    cyc(LOAD, 3'b010, 1'b0, 1'b1);
    chk("rst_mid_wb_state", {9'd0, last_s[2:0]}, 12'd0);
    chk("rst_mid_wb_rw", {11'd0, last_s[10]}, 12'd0);
    cyc(LOAD, 3'b010, 1'b0, 1'b0);
    chk("after_rst_no_rw", {11'd0, last_s[10]}, 12'd0);

    // Randomised run against the model
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      cyc(op, 3'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
      chk("excl_mem", {11'd0, last_s[9] & last_s[7]}, 12'd0);
      chk("excl_int_mret", {11'd0, last_a[4] & last_a[3]}, 12'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
